id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
Decode-to-execute pipeline register for the 5-stage core. It captures decoded instruction fields and register-file read data from the decode stage, and presents them as the E_* signals consumed by the hazard/forwarding unit and the execute stage. It supports three operations driven by pipeline control:
- hold (stall),
- bubble insertion (flush),
- invalid-slot capture.

It also keeps a saturating bubble counter for performance monitoring.

Parameters:
NOP_INSTR, 32'h00000013, encoding loaded into E_IR on reset or bubble (addi x0,x0,0)
CNT_W, 32, width of the bubble counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
STALL  input  1  hold current E_* contents
FLUSH  input  1  load a bubble into E_*
D_VALID  input  1  decode slot holds a real instruction
D_PC  input  32  decode PC
D_IR  input  32  decode instruction word
D_ADDR1  input  5  rs1 index
D_ADDR2  input  5  rs2 index
D_WADDR  input  5  rd index
D_RS1  input  32  rs1 read data
D_RS2  input  32  rs2 read data
D_IMM  input  32  sign-extended immediate
D_REG_WRITE  input  1  writes rd
D_MEM_READ  input  1  load
D_MEM_WRITE  input  1  store
D_WB_SEL  input  2  writeback source select
D_ALU_FUN  input  4  ALU operation
E_VALID  output  1  execute slot holds a real instruction
E_PC, E_IR, E_RS1, E_RS2, E_IMM  output  32 each  registered copies
E_ADDR1, E_ADDR2, E_WADDR  output  5 each  registered copies
E_REG_WRITE, E_MEM_READ, E_MEM_WRITE  output  1 each  registered control
E_WB_SEL  output  2  registered
E_ALU_FUN  output  4  registered
BUBBLE_CNT  output  CNT_W  count of bubbles entered into execute

Behaviour:
- All outputs are registered. Latency is 1 cycle from D_* to E_*. There is no combinational path from inputs to outputs.
- Bubble state:
  - E_VALID=0, E_IR=NOP_INSTR.
  - E_PC, E_RS1, E_RS2, E_IMM = 0.
  - E_ADDR1, E_ADDR2, E_WADDR = 0.
  - E_REG_WRITE, E_MEM_READ, E_MEM_WRITE = 0.
  - E_WB_SEL=0, E_ALU_FUN=0.
- Reset: when RST=1 at an edge, load the bubble state and set BUBBLE_CNT=0. RST overrides STALL and FLUSH. Reset applied mid-stall or mid-flush discards the held contents.
- Per-edge priority when RST=0:
  1. FLUSH=1: load the bubble state and increment BUBBLE_CNT. FLUSH wins over a simultaneous STALL, so a squashed instruction never survives a hold.
  2. STALL=1: all E_* and BUBBLE_CNT hold their values.
  3. D_VALID=0: load the bubble state and increment BUBBLE_CNT.
  4. Otherwise: capture all D_* fields and set E_VALID=1.
- x0 rule: on capture, E_REG_WRITE = D_REG_WRITE && (D_WADDR != 0). This prevents the hazard unit from forwarding or stalling on x0. E_WADDR itself is still captured as given.
- Control on capture: E_MEM_READ and E_MEM_WRITE are captured unmodified. If both are 1, both are passed through; illegal encodings are decode's responsibility.
- Addresses with no source operand: E_ADDR1/E_ADDR2 are captured even when the instruction has no rs1/rs2 (e.g. LUI). Forwarding qualification is the hazard unit's job.
- BUBBLE_CNT:
  - Increments by 1 per bubble loaded.
  - Saturates at all-ones and does not wrap.
  - Held cycles never count.
- A stalled-then-released instruction is captured from D_* on the first non-stall edge. Decode is required to hold D_* stable during STALL.

Test Plan:
- Reset: RST=1 for 2 cycles with D_VALID=1 and random D_* -> E_VALID=0, E_IR=32'h00000013, all control 0, BUBBLE_CNT=0.
- Normal capture:
  - Stimulus: D_PC=32'h100, D_IR=32'h00208033 (add x0? no: add x0,x1,x2), D_ADDR1=1, D_ADDR2=2, D_WADDR=5, D_REG_WRITE=1, D_RS1=7, D_RS2=9.
  - Required next cycle: E_* match, E_REG_WRITE=1, E_VALID=1.
  - Repeat with D_WADDR=0: E_REG_WRITE=0, E_WADDR=0.
- Stall hold: capture a load (D_MEM_READ=1, D_WADDR=3), then STALL=1 for 3 cycles while D_* changes -> E_* unchanged all 3 cycles, BUBBLE_CNT unchanged.
- Flush vs stall: STALL=1 and FLUSH=1 on the same edge with valid E contents -> bubble state loaded, BUBBLE_CNT +1. Next cycle with STALL=1 only: bubble held, count unchanged.
- Invalid slot: D_VALID=0 for 4 consecutive cycles with D_REG_WRITE=1 -> E_VALID=0, E_REG_WRITE=0 each cycle, BUBBLE_CNT increases by 4.
- Saturation and reset priority:
  - Saturation: with CNT_W=4, insert 20 bubbles -> BUBBLE_CNT stops at 4'hF.
  - Reset priority: assert RST together with FLUSH -> BUBBLE_CNT=0, not 1.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute pipeline register.
//   Captures decoded fields and register-file read data from decode and
//   presents them to the hazard/forwarding unit and the execute stage.
//   Supports hold (STALL), bubble insertion (FLUSH) and invalid-slot capture
//   (D_VALID=0). A saturating counter tracks bubbles entering execute.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   STALL, FLUSH             pipeline control (RST > FLUSH > STALL > D_VALID)
//   D_*                      decode-stage fields
//   E_*                      registered execute-stage copies, 1-cycle latency
//   BUBBLE_CNT               saturating count of bubbles loaded
module id_ex_pipe_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             D_VALID,
  input  logic [31:0]      D_PC,
  input  logic [31:0]      D_IR,
  input  logic [4:0]       D_ADDR1,
  input  logic [4:0]       D_ADDR2,
  input  logic [4:0]       D_WADDR,
  input  logic [31:0]      D_RS1,
  input  logic [31:0]      D_RS2,
  input  logic [31:0]      D_IMM,
  input  logic             D_REG_WRITE,
  input  logic             D_MEM_READ,
  input  logic             D_MEM_WRITE,
  input  logic [1:0]       D_WB_SEL,
  input  logic [3:0]       D_ALU_FUN,
  output logic             E_VALID,
  output logic [31:0]      E_PC,
  output logic [31:0]      E_IR,
  output logic [31:0]      E_RS1,
  output logic [31:0]      E_RS2,
  output logic [31:0]      E_IMM,
  output logic [4:0]       E_ADDR1,
  output logic [4:0]       E_ADDR2,
  output logic [4:0]       E_WADDR,
  output logic             E_REG_WRITE,
  output logic             E_MEM_READ,
  output logic             E_MEM_WRITE,
  output logic [1:0]       E_WB_SEL,
  output logic [3:0]       E_ALU_FUN,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  wb;
    logic [3:0]  alu;
  } ex_t;

  ex_t             ex_q;
  ex_t             bubble;
  ex_t             cap;
  logic [CNT_W-1:0] cnt_q;
  logic             load_bubble;

  always_comb begin
    bubble    = '0;
    bubble.ir = NOP_INSTR;
  end

  always_comb begin
    cap     = '0;
    cap.vld = 1'b1;
    cap.pc  = D_PC;
    cap.ir  = D_IR;
    cap.rs1 = D_RS1;
    cap.rs2 = D_RS2;
    cap.imm = D_IMM;
    cap.a1  = D_ADDR1;
    cap.a2  = D_ADDR2;
    cap.wa  = D_WADDR;
    // x0 is never a real destination; masking here keeps the hazard unit
    // from forwarding or stalling on it.
    cap.rw  = D_REG_WRITE && (D_WADDR != 5'd0);
    cap.mr  = D_MEM_READ;
    cap.mw  = D_MEM_WRITE;
    cap.wb  = D_WB_SEL;
    cap.alu = D_ALU_FUN;
  end

  // FLUSH beats STALL so a squashed instruction cannot survive a hold.
  assign load_bubble = FLUSH || (!STALL && !D_VALID);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= bubble;
      cnt_q <= '0;
    end else if (load_bubble) begin
      ex_q <= bubble;
      if (cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end else if (!STALL) begin
      ex_q <= cap;
    end
  end

  assign E_VALID     = ex_q.vld;
  assign E_PC        = ex_q.pc;
  assign E_IR        = ex_q.ir;
  assign E_RS1       = ex_q.rs1;
  assign E_RS2       = ex_q.rs2;
  assign E_IMM       = ex_q.imm;
  assign E_ADDR1     = ex_q.a1;
  assign E_ADDR2     = ex_q.a2;
  assign E_WADDR     = ex_q.wa;
  assign E_REG_WRITE = ex_q.rw;
  assign E_MEM_READ  = ex_q.mr;
  assign E_MEM_WRITE = ex_q.mw;
  assign E_WB_SEL    = ex_q.wb;
  assign E_ALU_FUN   = ex_q.alu;
  assign BUBBLE_CNT  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a table of directed vectors with hand-computed
// expectations, plus a saturation/reset-priority sequence on a CNT_W=4 copy.
module tb_id_ex_pipe_reg;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, D_VALID;
  logic [31:0] D_PC, D_IR, D_RS1, D_RS2, D_IMM;
  logic [4:0]  D_ADDR1, D_ADDR2, D_WADDR;
  logic        D_REG_WRITE, D_MEM_READ, D_MEM_WRITE;
  logic [1:0]  D_WB_SEL;
  logic [3:0]  D_ALU_FUN;

  logic        E_VALID, E_REG_WRITE, E_MEM_READ, E_MEM_WRITE;
  logic [31:0] E_PC, E_IR, E_RS1, E_RS2, E_IMM;
  logic [4:0]  E_ADDR1, E_ADDR2, E_WADDR;
  logic [1:0]  E_WB_SEL;
  logic [3:0]  E_ALU_FUN;
  logic [31:0] BUBBLE_CNT;

  logic        s_valid, s_rw, s_mr, s_mw;
  logic [31:0] s_pc, s_ir, s_rs1, s_rs2, s_imm;
  logic [4:0]  s_a1, s_a2, s_wa;
  logic [1:0]  s_wb;
  logic [3:0]  s_alu;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_pipe_reg #(.NOP_INSTR(32'h00000013), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .D_VALID(D_VALID),
    .D_PC(D_PC), .D_IR(D_IR), .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2),
    .D_WADDR(D_WADDR), .D_RS1(D_RS1), .D_RS2(D_RS2), .D_IMM(D_IMM),
    .D_REG_WRITE(D_REG_WRITE), .D_MEM_READ(D_MEM_READ),
    .D_MEM_WRITE(D_MEM_WRITE), .D_WB_SEL(D_WB_SEL), .D_ALU_FUN(D_ALU_FUN),
    .E_VALID(E_VALID), .E_PC(E_PC), .E_IR(E_IR), .E_RS1(E_RS1),
    .E_RS2(E_RS2), .E_IMM(E_IMM), .E_ADDR1(E_ADDR1), .E_ADDR2(E_ADDR2),
    .E_WADDR(E_WADDR), .E_REG_WRITE(E_REG_WRITE), .E_MEM_READ(E_MEM_READ),
    .E_MEM_WRITE(E_MEM_WRITE), .E_WB_SEL(E_WB_SEL), .E_ALU_FUN(E_ALU_FUN),
    .BUBBLE_CNT(BUBBLE_CNT)
  );

  id_ex_pipe_reg #(.NOP_INSTR(32'h00000013), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .D_VALID(D_VALID),
    .D_PC(D_PC), .D_IR(D_IR), .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2),
    .D_WADDR(D_WADDR), .D_RS1(D_RS1), .D_RS2(D_RS2), .D_IMM(D_IMM),
    .D_REG_WRITE(D_REG_WRITE), .D_MEM_READ(D_MEM_READ),
    .D_MEM_WRITE(D_MEM_WRITE), .D_WB_SEL(D_WB_SEL), .D_ALU_FUN(D_ALU_FUN),
    .E_VALID(s_valid), .E_PC(s_pc), .E_IR(s_ir), .E_RS1(s_rs1),
    .E_RS2(s_rs2), .E_IMM(s_imm), .E_ADDR1(s_a1), .E_ADDR2(s_a2),
    .E_WADDR(s_wa), .E_REG_WRITE(s_rw), .E_MEM_READ(s_mr),
    .E_MEM_WRITE(s_mw), .E_WB_SEL(s_wb), .E_ALU_FUN(s_alu),
    .BUBBLE_CNT(s_cnt)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc, ir;
    logic [4:0]  a1, a2, wa;
    logic [31:0] rs1, rs2, imm;
    logic        rw, mr, mw;
    logic [1:0]  wb;
    logic [3:0]  alu;
  } fld_t;

  typedef struct {
    string       nm;
    logic        rst, stall, flush;
    fld_t        d;
    fld_t        e;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic fld_t mk(logic vld, logic [31:0] pc, logic [31:0] ir,
                              logic [4:0] a1, logic [4:0] a2, logic [4:0] wa,
                              logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic rw, logic mr, logic mw,
                              logic [1:0] wb, logic [3:0] alu);
    fld_t f;
    f.vld = vld; f.pc = pc; f.ir = ir; f.a1 = a1; f.a2 = a2; f.wa = wa;
    f.rs1 = rs1; f.rs2 = rs2; f.imm = imm; f.rw = rw; f.mr = mr; f.mw = mw;
    f.wb = wb; f.alu = alu;
    return f;
  endfunction

  task automatic add(string nm, logic rst, logic stall, logic flush,
                     fld_t d, fld_t e, logic [31:0] cnt);
    vec_t v;
    v.nm = nm; v.rst = rst; v.stall = stall; v.flush = flush;
    v.d = d; v.e = e; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic stall, logic flush, fld_t d);
    RST = rst; STALL = stall; FLUSH = flush;
    D_VALID = d.vld; D_PC = d.pc; D_IR = d.ir;
    D_ADDR1 = d.a1; D_ADDR2 = d.a2; D_WADDR = d.wa;
    D_RS1 = d.rs1; D_RS2 = d.rs2; D_IMM = d.imm;
    D_REG_WRITE = d.rw; D_MEM_READ = d.mr; D_MEM_WRITE = d.mw;
    D_WB_SEL = d.wb; D_ALU_FUN = d.alu;
  endtask

  task automatic chk_e(string nm, fld_t e);
    chk({nm, ".valid"}, {31'd0, E_VALID}, {31'd0, e.vld});
    chk({nm, ".pc"}, E_PC, e.pc);
    chk({nm, ".ir"}, E_IR, e.ir);
    chk({nm, ".addr1"}, {27'd0, E_ADDR1}, {27'd0, e.a1});
    chk({nm, ".addr2"}, {27'd0, E_ADDR2}, {27'd0, e.a2});
    chk({nm, ".waddr"}, {27'd0, E_WADDR}, {27'd0, e.wa});
    chk({nm, ".rs1"}, E_RS1, e.rs1);
    chk({nm, ".rs2"}, E_RS2, e.rs2);
    chk({nm, ".imm"}, E_IMM, e.imm);
    chk({nm, ".ctl"}, {29'd0, E_REG_WRITE, E_MEM_READ, E_MEM_WRITE},
        {29'd0, e.rw, e.mr, e.mw});
    chk({nm, ".wb_sel"}, {30'd0, E_WB_SEL}, {30'd0, e.wb});
    chk({nm, ".alu_fun"}, {28'd0, E_ALU_FUN}, {28'd0, e.alu});
  endtask

  fld_t bub, da, add_i, add0_i, add0_e, ld, oth, both, inv, lui;

  initial begin
    bub    = mk(0, 32'h0,   32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    da     = mk(1, 32'h200, 32'hdeadbeef, 7, 8, 9, 32'h11, 32'h22, 32'h33,
                1, 1, 0, 2'd2, 4'd5);
    add_i  = mk(1, 32'h100, 32'h00208033, 1, 2, 5, 7, 9, 0, 1, 0, 0, 0, 0);
    add0_i = mk(1, 32'h100, 32'h00208033, 1, 2, 0, 7, 9, 0, 1, 0, 0, 0, 0);
    add0_e = mk(1, 32'h100, 32'h00208033, 1, 2, 0, 7, 9, 0, 0, 0, 0, 0, 0);
    ld     = mk(1, 32'h104, 32'h0101a183, 3, 0, 3, 32'h1000, 0, 32'h10,
                1, 1, 0, 2'd1, 4'd0);
    oth    = mk(1, 32'h108, 32'h00c000ef, 4, 5, 6, 1, 2, 3, 1, 0, 1, 0, 4'd3);
    both   = mk(1, 32'h10c, 32'h00112023, 1, 1, 0, 5, 6, 0, 0, 1, 1, 0, 0);
    inv    = mk(0, 32'h110, 32'h00500093, 0, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    lui    = mk(1, 32'h114, 32'h123452b7, 5'd5, 5'd3, 5, 0, 0, 32'h12345000,
                1, 0, 0, 0, 4'hb);

    //   name          rst stall flush  D      expected  cnt
    add("rst0",         1, 0, 0, da,     bub,    0);
    add("rst1",         1, 0, 0, da,     bub,    0);
    add("cap_add",      0, 0, 0, add_i,  add_i,  0);
    add("cap_x0",       0, 0, 0, add0_i, add0_e, 0);
    add("cap_load",     0, 0, 0, ld,     ld,     0);
    add("stall1",       0, 1, 0, oth,    ld,     0);
    add("stall2",       0, 1, 0, da,     ld,     0);
    add("stall3",       0, 1, 0, add_i,  ld,     0);
    add("flush_stall",  0, 1, 1, oth,    bub,    1);
    add("stall_bub",    0, 1, 0, oth,    bub,    1);
    add("cap_rdwr",     0, 0, 0, both,   both,   1);
    add("inv1",         0, 0, 0, inv,    bub,    2);
    add("inv2",         0, 0, 0, inv,    bub,    3);
    add("inv3",         0, 0, 0, inv,    bub,    4);
    add("inv4",         0, 0, 0, inv,    bub,    5);
    add("stall_inv",    0, 1, 0, inv,    bub,    5);
    add("cap_lui",      0, 0, 0, lui,    lui,    5);
    add("rst_flush",    1, 0, 1, add_i,  bub,    0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].d);
      @(posedge CLK); #1;
      chk_e(vecs[i].nm, vecs[i].e);
      chk({vecs[i].nm, ".cnt"}, BUBBLE_CNT, vecs[i].cnt);
      chk({vecs[i].nm, ".cnt4"}, {28'd0, s_cnt}, vecs[i].cnt);
    end

    // Saturation: 20 flushes into the 4-bit counter stop at 4'hF.
    drive(1, 0, 0, add_i);
    @(posedge CLK); #1;
    chk("sat_rst.cnt4", {28'd0, s_cnt}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 1, add_i);
      @(posedge CLK); #1;
      chk($sformatf("sat%0d.cnt4", k), {28'd0, s_cnt}, (k > 15) ? 32'd15 : k);
      chk($sformatf("sat%0d.cnt", k), BUBBLE_CNT, k);
      chk($sformatf("sat%0d.valid", k), {31'd0, s_valid}, 32'd0);
    end

    // Held cycles never count, even while saturated.
    drive(0, 1, 0, add_i);
    @(posedge CLK); #1;
    chk("sat_hold.cnt", BUBBLE_CNT, 32'd20);
    chk("sat_hold.cnt4", {28'd0, s_cnt}, 32'd15);

    // Reset beats a simultaneous flush.
    drive(1, 0, 1, add_i);
    @(posedge CLK); #1;
    chk("rst_pri.cnt", BUBBLE_CNT, 32'd0);
    chk("rst_pri.cnt4", {28'd0, s_cnt}, 32'd0);
    chk_e("rst_pri", bub);

    // Released instruction is captured on the first non-stall edge.
    drive(0, 0, 0, ld);
    @(posedge CLK); #1;
    drive(0, 1, 0, oth);
    @(posedge CLK); #1;
    chk_e("rel_hold", ld);
    drive(0, 0, 0, oth);
    @(posedge CLK); #1;
    chk_e("rel_cap", oth);
    chk("rel_cap.cnt", BUBBLE_CNT, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
